// File: rtl/beta_pkg.sv
// Shared definitions for the Beta control sequencer and its datapath slaves.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package beta_pkg;

   // Opcodes with a fixed meaning outside the ALU groups
   localparam logic [5:0] OP_LD  = 6'h18;
   localparam logic [5:0] OP_ST  = 6'h19;
   localparam logic [5:0] OP_JMP = 6'h1B;
   localparam logic [5:0] OP_BEQ = 6'h1C;
   localparam logic [5:0] OP_BNE = 6'h1D;

   // ALU function codes, shared with the ALU
   localparam logic [4:0] ALU_ADD   = 5'b00000;
   localparam logic [4:0] ALU_SUB   = 5'b00001;
   localparam logic [4:0] ALU_CMPEQ = 5'b00101;
   localparam logic [4:0] ALU_CMPLT = 5'b00111;
   localparam logic [4:0] ALU_CMPLE = 5'b01111;
   localparam logic [4:0] ALU_SHL   = 5'b01000;
   localparam logic [4:0] ALU_SHR   = 5'b01001;
   localparam logic [4:0] ALU_SRA   = 5'b01011;
   localparam logic [4:0] ALU_AND   = 5'b11000;
   localparam logic [4:0] ALU_OR    = 5'b11110;
   localparam logic [4:0] ALU_XOR   = 5'b10110;

   typedef enum logic [2:0] {
      ST_RST    = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      WD_PC4 = 2'd0,
      WD_ALU = 2'd1,
      WD_MEM = 2'd2
   } wdsel_e;

   typedef enum logic [1:0] {
      PC_PLUS4 = 2'd0,
      PC_BR    = 2'd1,
      PC_JMP   = 2'd2,
      PC_ILLOP = 2'd3
   } pcsel_e;

   typedef enum logic [2:0] {
      CLS_ALU = 3'd0,
      CLS_LD  = 3'd1,
      CLS_ST  = 3'd2,
      CLS_JMP = 3'd3,
      CLS_BEQ = 3'd4,
      CLS_BNE = 3'd5,
      CLS_ILL = 3'd6
   } cls_e;

endpackage

// File: rtl/beta_ctl_if.sv
// Control bus between the Beta sequencer and its datapath slaves.
// Latency: n/a (wires only).
// Backpressure: imem_ack / dmem_ack stretch fetch and memory phases.
// Ports: fetch (instr, imem_req, imem_ack), data memory (dmem_req, dmem_we,
// dmem_ack), register file (ra_zero, ra_addr, rb_addr, wa, werf, wdsel),
// ALU (aluop, bsel), PC (pcsel, pc_en).
interface beta_ctl_if;
   import beta_pkg::*;

   logic [31:0] instr;
   logic        imem_req;
   logic        imem_ack;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ack;
   logic        ra_zero;
   logic [4:0]  ra_addr;
   logic [4:0]  rb_addr;
   logic [4:0]  wa;
   logic [4:0]  aluop;
   logic        bsel;
   wdsel_e      wdsel;
   logic        werf;
   pcsel_e      pcsel;
   logic        pc_en;

   // Sequencer side
   modport master (
      input  instr, imem_ack, dmem_ack, ra_zero,
      output imem_req, dmem_req, dmem_we, ra_addr, rb_addr, wa,
             aluop, bsel, wdsel, werf, pcsel, pc_en
   );

   // Datapath / memory side
   modport slave (
      output instr, imem_ack, dmem_ack, ra_zero,
      input  imem_req, dmem_req, dmem_we, ra_addr, rb_addr, wa,
             aluop, bsel, wdsel, werf, pcsel, pc_en
   );

endinterface

// File: rtl/beta_decode.sv
// Opcode decoder: maps an opcode to ALU function, B-source select and class.
// Latency: combinational.
// Backpressure: none.
// Ports: opcode_i (IR[31:26]); aluop_o, bsel_o, cls_o.
module beta_decode
   import beta_pkg::*;
(
   input  logic [5:0] opcode_i,
   output logic [4:0] aluop_o,
   output logic       bsel_o,
   output cls_e       cls_o
);

   always_comb begin
      aluop_o = ALU_ADD;
      bsel_o  = 1'b0;
      cls_o   = CLS_ILL;

      // Register (0x2x) and constant (0x3x) ALU forms share the low nibble;
      // opcode bit 4 alone selects the literal as B operand.
      if (opcode_i[5] == 1'b1) begin
         cls_o  = CLS_ALU;
         bsel_o = opcode_i[4];
         unique case (opcode_i[3:0])
            4'h0:    aluop_o = ALU_ADD;
            4'h1:    aluop_o = ALU_SUB;
            4'h4:    aluop_o = ALU_CMPEQ;
            4'h5:    aluop_o = ALU_CMPLT;
            4'h6:    aluop_o = ALU_CMPLE;
            4'h8:    aluop_o = ALU_AND;
            4'h9:    aluop_o = ALU_OR;
            4'hA:    aluop_o = ALU_XOR;
            4'hC:    aluop_o = ALU_SHL;
            4'hD:    aluop_o = ALU_SHR;
            4'hE:    aluop_o = ALU_SRA;
            // MUL, DIV and unassigned slots trap as illegal
            default: begin
               cls_o  = CLS_ILL;
               bsel_o = 1'b0;
            end
         endcase
      end else begin
         unique case (opcode_i)
            OP_LD: begin
               cls_o  = CLS_LD;
               bsel_o = 1'b1;
            end
            OP_ST: begin
               cls_o  = CLS_ST;
               bsel_o = 1'b1;
            end
            OP_JMP:  cls_o = CLS_JMP;
            OP_BEQ:  cls_o = CLS_BEQ;
            OP_BNE:  cls_o = CLS_BNE;
            default: cls_o = CLS_ILL;
         endcase
      end
   end

endmodule

// File: rtl/beta_ctl.sv
// Multi-cycle Beta sequencer: fetch, decode, execute, memory, write-back.
// Latency: 3 cycles ALU/branch/JMP/illegal, 4 ST, 5 LD (acks same cycle).
// Backpressure: holds in FETCH until imem_ack and in MEM until dmem_ack.
// Ports: clk, reset (async, active-high); bus (master side of beta_ctl_if).
module beta_ctl
   import beta_pkg::*;
#(
   parameter logic [4:0] XP_REG = 5'd30
)
(
   input  logic       clk,
   input  logic       reset,
   beta_ctl_if.master bus
);

   state_e      state_q, state_d;
   logic [31:0] ir_q, ir_d;

   logic [5:0]  opcode;
   logic [4:0]  rc, ra, rb;
   logic [4:0]  dec_aluop;
   logic        dec_bsel;
   cls_e        dec_cls;

   assign opcode = ir_q[31:26];
   assign rc     = ir_q[25:21];
   assign ra     = ir_q[20:16];
   assign rb     = ir_q[15:11];

   // Low literal bits feed the datapath sign-extender, not the sequencer
   logic unused_lit;
   assign unused_lit = ^ir_q[10:0];

   beta_decode u_decode (
      .opcode_i (opcode),
      .aluop_o  (dec_aluop),
      .bsel_o   (dec_bsel),
      .cls_o    (dec_cls)
   );

   // Instruction register: captured only on a fetch acknowledge
   assign ir_d = (state_q == ST_FETCH && bus.imem_ack) ? bus.instr : ir_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ir_q <= '0;
      end else begin
         ir_q <= ir_d;
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RST;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RST:    state_d = ST_FETCH;
         ST_FETCH:  if (bus.imem_ack) state_d = ST_DECODE;
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC:   state_d = (dec_cls == CLS_LD || dec_cls == CLS_ST) ? ST_MEM : ST_FETCH;
         ST_MEM:    if (bus.dmem_ack) state_d = (dec_cls == CLS_LD) ? ST_WB : ST_FETCH;
         ST_WB:     state_d = ST_FETCH;
         default:   state_d = ST_RST;
      endcase
   end

   // Output decode
   always_comb begin
      bus.imem_req = 1'b0;
      bus.dmem_req = 1'b0;
      bus.dmem_we  = 1'b0;
      bus.ra_addr  = '0;
      bus.rb_addr  = '0;
      bus.wa       = '0;
      bus.aluop    = ALU_ADD;
      bus.bsel     = 1'b0;
      bus.wdsel    = WD_PC4;
      bus.werf     = 1'b0;
      bus.pcsel    = PC_PLUS4;
      bus.pc_en    = 1'b0;

      // Register read addresses stay stable from DECODE through WB;
      // ST reads its data register through the rc field.
      if (state_q != ST_RST && state_q != ST_FETCH) begin
         bus.ra_addr = ra;
         bus.rb_addr = (dec_cls == CLS_ST) ? rc : rb;
      end

      unique case (state_q)
         ST_FETCH: bus.imem_req = 1'b1;
         ST_EXEC: begin
            bus.aluop = dec_aluop;
            bus.bsel  = dec_bsel;
            unique case (dec_cls)
               CLS_ALU: begin
                  bus.werf  = 1'b1;
                  bus.wa    = rc;
                  bus.wdsel = WD_ALU;
                  bus.pc_en = 1'b1;
               end
               CLS_LD, CLS_ST: ;
               CLS_JMP: begin
                  bus.werf  = 1'b1;
                  bus.wa    = rc;
                  bus.pcsel = PC_JMP;
                  bus.pc_en = 1'b1;
               end
               CLS_BEQ: begin
                  bus.werf  = 1'b1;
                  bus.wa    = rc;
                  bus.pc_en = 1'b1;
                  bus.pcsel = bus.ra_zero ? PC_BR : PC_PLUS4;
               end
               CLS_BNE: begin
                  bus.werf  = 1'b1;
                  bus.wa    = rc;
                  bus.pc_en = 1'b1;
                  bus.pcsel = bus.ra_zero ? PC_PLUS4 : PC_BR;
               end
               default: begin
                  // Illegal opcode: save PC+4 in XP and trap
                  bus.werf  = 1'b1;
                  bus.wa    = XP_REG;
                  bus.pcsel = PC_ILLOP;
                  bus.pc_en = 1'b1;
               end
            endcase
         end
         ST_MEM: begin
            bus.dmem_req = 1'b1;
            bus.dmem_we  = (dec_cls == CLS_ST);
            bus.aluop    = ALU_ADD;
            bus.bsel     = 1'b1;
            // A store retires on the ack itself, so its PC advance follows
            // dmem_ack combinationally.
            if (dec_cls == CLS_ST && bus.dmem_ack) begin
               bus.pc_en = 1'b1;
            end
         end
         ST_WB: begin
            bus.werf  = 1'b1;
            bus.wa    = rc;
            bus.wdsel = WD_MEM;
            bus.pc_en = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_beta_ctl.sv
// Directed bench for beta_ctl: table of single-pass instructions plus
// hand-written LD, ST and reset-during-MEM sequences.
module tb_beta_ctl;
   import beta_pkg::*;

   logic clk;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   beta_ctl_if bif ();

   beta_ctl #(.XP_REG(5'd30)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic        ra_zero;
      logic [4:0]  aluop;
      logic        bsel;
      logic [4:0]  wa;
      logic [1:0]  wdsel;
      logic [1:0]  pcsel;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({bif.imem_req, bif.dmem_req, bif.dmem_we, bif.ra_addr, bif.rb_addr,
                  bif.wa, bif.aluop, bif.bsel, bif.wdsel, bif.werf, bif.pcsel, bif.pc_en});
   endfunction

   // Waits (bounded) for a fetch request, presents w with an immediate ack,
   // and returns #1 into the DECODE cycle.
   task automatic do_fetch(input logic [31:0] w);
      int n = 0;
      while (bif.imem_req !== 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("fetch_req", 32'(bif.imem_req), 32'd1);
      bif.instr    = w;
      bif.imem_ack = 1'b1;
      @(posedge clk);
      #1;
      bif.imem_ack = 1'b0;
      bif.instr    = '0;
   endtask

   initial begin
      int req_cnt;
      int pc_cnt;
      logic we_seen;

      vecs[0]  = '{"add",    32'h80221800, 1'b0, 5'b00000, 1'b0, 5'd1,  2'd1, 2'd0};
      vecs[1]  = '{"addc",   32'hC085FFFC, 1'b0, 5'b00000, 1'b1, 5'd4,  2'd1, 2'd0};
      vecs[2]  = '{"xorc",   32'hE8C70001, 1'b0, 5'b10110, 1'b1, 5'd6,  2'd1, 2'd0};
      vecs[3]  = '{"sub",    32'h84411800, 1'b0, 5'b00001, 1'b0, 5'd2,  2'd1, 2'd0};
      vecs[4]  = '{"sra",    32'hB9200800, 1'b0, 5'b01011, 1'b0, 5'd9,  2'd1, 2'd0};
      vecs[5]  = '{"cmple",  32'h98600000, 1'b0, 5'b01111, 1'b0, 5'd3,  2'd1, 2'd0};
      vecs[6]  = '{"beq_t",  32'h73E10004, 1'b1, 5'b00000, 1'b0, 5'd31, 2'd0, 2'd1};
      vecs[7]  = '{"beq_nt", 32'h73E10004, 1'b0, 5'b00000, 1'b0, 5'd31, 2'd0, 2'd0};
      vecs[8]  = '{"bne_t",  32'h74A00008, 1'b0, 5'b00000, 1'b0, 5'd5,  2'd0, 2'd1};
      vecs[9]  = '{"bne_nt", 32'h74A00008, 1'b1, 5'b00000, 1'b0, 5'd5,  2'd0, 2'd0};
      vecs[10] = '{"jmp",    32'h6CE20000, 1'b0, 5'b00000, 1'b0, 5'd7,  2'd0, 2'd2};
      vecs[11] = '{"mul",    32'h88221800, 1'b0, 5'b00000, 1'b0, 5'd30, 2'd0, 2'd3};
      vecs[12] = '{"divc",   32'hCC000000, 1'b0, 5'b00000, 1'b0, 5'd30, 2'd0, 2'd3};
      vecs[13] = '{"op00",   32'h00200000, 1'b0, 5'b00000, 1'b0, 5'd30, 2'd0, 2'd3};
      vecs[14] = '{"xnor",   32'hAC000000, 1'b0, 5'b00000, 1'b0, 5'd30, 2'd0, 2'd3};

      bif.instr    = '0;
      bif.imem_ack = 1'b0;
      bif.dmem_ack = 1'b0;
      bif.ra_zero  = 1'b0;
      reset        = 1'b0;
      #1 reset     = 1'b1;
      #20;
      chk("reset_outs", all_outs(), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_state_req", 32'(bif.imem_req), 32'd0);
      @(posedge clk);
      #1;
      chk("fetch_after_rst", 32'({bif.imem_req, bif.werf, bif.pc_en}), 32'b100);

      // Single-pass instructions
      for (int i = 0; i < 15; i++) begin
         bif.ra_zero = vecs[i].ra_zero;
         do_fetch(vecs[i].instr);
         chk({vecs[i].name, "_decode"},
             32'({bif.ra_addr, bif.rb_addr, bif.werf, bif.pc_en, bif.imem_req}),
             32'({vecs[i].instr[20:16], vecs[i].instr[15:11], 3'b000}));
         @(posedge clk);
         #1;
         chk({vecs[i].name, "_exec"},
             32'({bif.werf, bif.wa, bif.aluop, bif.bsel, bif.wdsel, bif.pcsel,
                  bif.pc_en, bif.imem_req, bif.dmem_req}),
             32'({1'b1, vecs[i].wa, vecs[i].aluop, vecs[i].bsel, vecs[i].wdsel,
                  vecs[i].pcsel, 1'b1, 1'b0, 1'b0}));
         @(posedge clk);
         #1;
         chk({vecs[i].name, "_refetch"}, 32'({bif.imem_req, bif.pc_en, bif.werf}), 32'b100);
      end
      bif.ra_zero = 1'b0;

      // LD r8, 4(r2) with dmem_ack three cycles late
      do_fetch(32'h61020004);
      @(posedge clk);
      #1;
      chk("ld_exec", 32'({bif.aluop, bif.bsel, bif.werf, bif.pc_en, bif.dmem_req}),
          32'({5'b00000, 1'b1, 3'b000}));
      pc_cnt = int'(bif.pc_en);
      @(posedge clk);
      #1;
      chk("ld_mem_addr", 32'({bif.aluop, bif.bsel}), 32'({5'b00000, 1'b1}));
      req_cnt = 0;
      we_seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (bif.dmem_req) req_cnt++;
         we_seen = we_seen | bif.dmem_we;
         pc_cnt  = pc_cnt + int'(bif.pc_en);
         if (c == 3) bif.dmem_ack = 1'b1;
         @(posedge clk);
         #1;
      end
      bif.dmem_ack = 1'b0;
      chk("ld_wb", 32'({bif.werf, bif.wa, bif.wdsel, bif.pc_en, bif.dmem_req}),
          32'({1'b1, 5'd8, 2'd2, 1'b1, 1'b0}));
      pc_cnt = pc_cnt + int'(bif.pc_en);
      chk("ld_req_cycles", 32'(req_cnt), 32'd4);
      chk("ld_we", 32'(we_seen), 32'd0);
      chk("ld_pc_en_count", 32'(pc_cnt), 32'd1);
      @(posedge clk);
      #1;
      chk("ld_refetch", 32'({bif.imem_req, bif.pc_en}), 32'b10);

      // ST r3, 8(r1) with immediate ack
      do_fetch(32'h64610008);
      chk("st_decode", 32'({bif.ra_addr, bif.rb_addr}), 32'({5'd1, 5'd3}));
      @(posedge clk);
      #1;
      chk("st_exec", 32'({bif.werf, bif.pc_en, bif.bsel, bif.dmem_req}), 32'b0010);
      @(posedge clk);
      #1;
      chk("st_mem_noack", 32'({bif.dmem_req, bif.dmem_we, bif.pc_en, bif.bsel}), 32'b1101);
      bif.dmem_ack = 1'b1;
      #1;
      chk("st_mem_ack", 32'({bif.pc_en, bif.pcsel, bif.werf}), 32'b1000);
      @(posedge clk);
      #1;
      bif.dmem_ack = 1'b0;
      chk("st_refetch", 32'({bif.imem_req, bif.dmem_req}), 32'b10);

      // Reset during MEM of a load, then a stale ack
      do_fetch(32'h61020004);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("rst_pre_mem", 32'(bif.dmem_req), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rst_async_outs", all_outs(), 32'd0);
      bif.dmem_ack = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_held_outs", all_outs(), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_stale_ack", 32'({bif.imem_req, bif.dmem_req, bif.werf, bif.pc_en}), 32'b1000);
      bif.dmem_ack = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_fetch_hold", 32'({bif.imem_req, bif.ra_addr}), 32'({1'b1, 5'd0}));
      do_fetch(32'h80221800);
      chk("rst_resume_decode", 32'({bif.ra_addr, bif.rb_addr}), 32'({5'd2, 5'd3}));
      @(posedge clk);
      #1;
      chk("rst_resume_exec", 32'({bif.werf, bif.wa, bif.wdsel, bif.pc_en, bif.aluop}),
          32'({1'b1, 5'd1, 2'd1, 1'b1, 5'b00000}));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/beta_ctl.md
# beta_ctl

Multi-cycle control sequencer for the Beta datapath: fetches an instruction over a request/acknowledge handshake, decodes it, and drives the ALU opcode and datapath selects for execute, memory and write-back. It is the initiator end of the ALU op interface; the ALU, register file and PC register are its slaves. One instruction is in flight at a time, with no overlap.

## Interface
Parameters:
- XP_REG, 5'd30, register written with PC+4 on an illegal opcode.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- instr  input  32  instruction word from instruction memory; valid while imem_ack=1.
- imem_req  output  1  instruction fetch request.
- imem_ack  input  1  fetch complete; instr is latched into IR on this cycle.
- dmem_req  output  1  data memory request.
- dmem_we  output  1  1 = store, 0 = load; valid while dmem_req=1.
- dmem_ack  input  1  data access complete.
- ra_zero  input  1  register-file read of Ra equals 0 (used for branches).
- ra_addr, rb_addr, wa  output  5  register read and write addresses.
- aluop  output  5  ALU function code.
- bsel  output  1  ALU B source: 0 = Rb, 1 = sign-extended literal.
- wdsel  output  2  write data: 0 = PC+4, 1 = ALU, 2 = memory.
- werf  output  1  register-file write enable.
- pcsel  output  2  next PC: 0 = PC+4, 1 = branch target, 2 = JMP (Ra), 3 = ILLOP vector.
- pc_en  output  1  PC register load enable.

## Operation
- Fields: opcode=IR[31:26], rc=IR[25:21], ra=IR[20:16], rb=IR[15:11], literal=IR[15:0].
- States: RST, FETCH, DECODE, EXEC, MEM, WB.
- RST: entered asynchronously on reset. All outputs are 0. Always moves to FETCH on the next edge.
- FETCH: imem_req=1. On imem_ack, load IR and go to DECODE. With no ack, hold.
- DECODE: ra_addr=ra. rb_addr=rb, or rc for ST. No other outputs asserted. Go to EXEC.
- EXEC: register addresses held. aluop and bsel are valid, taken from the decode table.
  - ALU ops (0x20–0x2E) and ALU-constant ops (0x30–0x3E): werf=1, wa=rc, wdsel=1, pc_en=1, pcsel=0. Then FETCH.
  - LD 0x18 / ST 0x19: aluop=ADD, bsel=1. Then MEM.
  - JMP 0x1B: werf=1, wa=rc, wdsel=0, pcsel=2, pc_en=1. Then FETCH.
  - BEQ 0x1C / BNE 0x1D: werf=1, wa=rc, wdsel=0, pc_en=1. pcsel=1 if the condition holds (BEQ: ra_zero=1; BNE: ra_zero=0), else 0. Then FETCH.
  - All other opcodes, including MUL 0x22/0x32 and DIV 0x23/0x33, are illegal: werf=1, wa=XP_REG, wdsel=0, pcsel=3, pc_en=1. Then FETCH.
- MEM: dmem_req=1. dmem_we=1 for ST. aluop=ADD and bsel=1 are held so the address stays stable. On dmem_ack: LD goes to WB; ST asserts pc_en=1, pcsel=0 and goes to FETCH. With no ack, hold.
- WB (LD only): werf=1, wa=rc, wdsel=2, pc_en=1, pcsel=0. Then FETCH.
- ALU codes: ADD 00000, SUB 00001, CMPEQ 00101, CMPLT 00111, CMPLE 01111, SHL 01000, SHR 01001, SRA 01011, AND 11000, OR 11110, XOR 10110.

## Timing
- Outputs are Moore-decoded from state and IR. No output depends combinationally on imem_ack or dmem_ack, except pc_en/pcsel in MEM for ST.
- Minimum latency, with acks in the same cycle as the request:
  - ALU, branch, JMP, illegal: 3 cycles.
  - ST: 4 cycles.
  - LD: 5 cycles.
- Exactly one pc_en pulse per instruction.
- werf is never asserted outside EXEC/WB.
- Reset asserted mid-instruction: state goes to RST immediately and all outputs drop to 0 asynchronously. IR resets to 0. Requests are abandoned; any late ack is ignored.
- An ack seen outside FETCH/MEM is ignored.

## Structure
- beta_pkg holds:
  - opcode constants;
  - ALU code constants, shared with the ALU;
  - the state enum;
  - wdsel and pcsel enums.
- Sub-module beta_decode: combinational, opcode → {aluop, bsel, class}. class is one of ALU, LD, ST, JMP, BEQ, BNE, ILL.
- beta_ctl holds IR, the state register and the output decode.

## Test plan
- Reset release, then fetch of ADD r1,r2,r3 (0x80221800) acked immediately:
  - imem_req=1 in the cycle after RST;
  - EXEC: aluop=00000, bsel=0, werf=1, wa=1, wdsel=1, pc_en=1.
- ADDC with literal 0xFFFC: EXEC bsel=1, aluop=00000. XORC: aluop=10110.
- LD, dmem_ack delayed 3 cycles:
  - dmem_req held for 4 cycles, dmem_we=0;
  - WB: werf=1, wdsel=2;
  - pc_en asserted once.
- BEQ with ra_zero=1 → pcsel=1. With ra_zero=0 → pcsel=0. Both cases: werf=1, wdsel=0.
- Opcode 0x22 (MUL) → werf=1, wa=30, pcsel=3, wdsel=0.
- Reset asserted during MEM with dmem_req=1: all outputs 0 in the same cycle; a stale dmem_ack is ignored; normal fetch resumes after release.
